// File: rtl/i3c_xfer_scheduler_pkg.sv
// Shared types for the I3C transfer scheduler: scheduler state encodings and
// fallback engine encodings for builds that do not pull in i3c_params.vh.
`ifndef STATE_WIDTH
`define STATE_WIDTH 3
`endif
`ifndef IDLE
`define IDLE 3'd0
`endif
`ifndef SCH_STATE_WIDTH
`define SCH_STATE_WIDTH 3
`define SCH_IDLE   3'd0
`define SCH_ARB    3'd1
`define SCH_LAUNCH 3'd2
`define SCH_WAIT   3'd3
`define SCH_RETRY  3'd4
`define SCH_RESP   3'd5
`endif

package i3c_xfer_scheduler_pkg;

    localparam int SCH_STATE_W = `SCH_STATE_WIDTH;

    typedef enum logic [SCH_STATE_W-1:0] {
        S_IDLE   = `SCH_IDLE,
        S_ARB    = `SCH_ARB,
        S_LAUNCH = `SCH_LAUNCH,
        S_WAIT   = `SCH_WAIT,
        S_RETRY  = `SCH_RETRY,
        S_RESP   = `SCH_RESP
    } sch_state_e;

endpackage

// File: rtl/i3c_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr_i,
// wrapping modulo N; returns a one-hot grant and the winner index.
module i3c_rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    logic [PTR_W-1:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = PTR_W'((int'(ptr_i) + i) % N);
            if (!valid_o && req_i[cand]) begin
                valid_o     = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/i3c_xfer_scheduler.sv
// Round-robin scheduler sharing one I3C transaction engine between NUM_REQ
// requesters, with retry. Define I3C_SCHED_TIMEOUT_EN to add the S_WAIT watchdog.
`ifndef STATE_WIDTH
`define STATE_WIDTH 3
`endif
`ifndef IDLE
`define IDLE 3'd0
`endif

module i3c_xfer_scheduler
    import i3c_xfer_scheduler_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int MAX_RETRY   = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [NUM_REQ-1:0]        err_o,
    output logic                      sm_start_o,
    output logic [ADDR_W-1:0]         sm_addr_o,
    output logic [DATA_W-1:0]         sm_data_o,
    input  logic [`STATE_WIDTH-1:0]   sm_state_i,
    input  logic                      sm_complete_i,
    input  logic                      sm_error_i,
    output logic                      busy_o,
    output sch_state_e                dbg_state_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    sch_state_e         state;
    logic [PTR_W-1:0]   rr_ptr;
    logic [2:0]         retry_cnt;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [PTR_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               eng_idle;
    logic               attempt_fail;

    assign eng_idle = (sm_state_i == `IDLE);

    i3c_rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (req_i),
        .ptr_i   (rr_ptr),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

`ifdef I3C_SCHED_TIMEOUT_EN
    localparam int WDOG_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

    logic [WDOG_W-1:0] wdog;
    logic              wdog_hit;

    assign wdog_hit = (state == S_WAIT) && (wdog == WDOG_W'(TIMEOUT_CYC - 1));

    // Held at zero outside S_WAIT, so every wait starts fresh; stops at the limit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wdog <= '0;
        end else if (state != S_WAIT) begin
            wdog <= '0;
        end else if (!wdog_hit) begin
            wdog <= wdog + 1'b1;
        end
    end

    assign attempt_fail = sm_error_i | wdog_hit;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYC;
    assign attempt_fail   = sm_error_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            rr_ptr    <= '0;
            retry_cnt <= '0;
            sm_addr_o <= '0;
            sm_data_o <= '0;
            gnt_o     <= '0;
            done_o    <= '0;
            err_o     <= '0;
        end else begin
            done_o <= '0;
            err_o  <= '0;
            case (state)
                S_IDLE: begin
                    if ((|req_i) && eng_idle) state <= S_ARB;
                end
                S_ARB: begin
                    if (arb_valid) begin
                        sm_addr_o <= req_addr_i[arb_idx*ADDR_W +: ADDR_W];
                        sm_data_o <= req_data_i[arb_idx*DATA_W +: DATA_W];
                        gnt_o     <= arb_gnt;
                        retry_cnt <= '0;
                        rr_ptr    <= (arb_idx == PTR_W'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
                        state     <= S_LAUNCH;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_LAUNCH: begin
                    if (eng_idle) state <= S_WAIT;
                end
                S_WAIT: begin
                    // Completion wins over a same-cycle error.
                    if (sm_complete_i) begin
                        done_o <= gnt_o;
                        state  <= S_RESP;
                    end else if (attempt_fail && (retry_cnt < 3'(MAX_RETRY))) begin
                        retry_cnt <= retry_cnt + 1'b1;
                        state     <= S_RETRY;
                    end else if (attempt_fail) begin
                        err_o <= gnt_o;
                        state <= S_RESP;
                    end
                end
                S_RETRY: begin
                    if (eng_idle) state <= S_LAUNCH;
                end
                S_RESP: begin
                    gnt_o <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The start pulse lasts the single S_LAUNCH cycle in which the engine is idle.
    assign sm_start_o  = (state == S_LAUNCH) && eng_idle;
    assign busy_o      = (state != S_IDLE);
    assign dbg_state_o = state;

endmodule
